mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multi-cycle multiply/divide unit for the Execute stage. It holds the HI/LO pair and runs signed and unsigned multiply, divide and multiply-accumulate with a configurable latency per operation class. It also supports direct HI/LO writes and flush/cancel for exception handling. The stage stalls dependent instructions on `busy || start`, so the unit is sized for that stall.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 2)
- `MUL_CYCLES`, 5, latency of mult/multu/madd/maddu/msub/msubu (≥ 1)
- `DIV_CYCLES`, 10, latency of div/divu (≥ 1)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  request; sampled every edge
- `mlu_op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11–15 none
- `D1`  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
- `D2`  in  WIDTH  rt operand (divisor / multiplier)
- `flush`  in  1  cancel in-flight op and same-cycle start
- `HI`  out  WIDTH  architectural HI
- `LO`  out  WIDTH  architectural LO
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse, registered, high in the cycle after commit

## Operation
- **Reset** (`reset`=0, async): HI=0, LO=0, busy=0, done=0, counter=0, shadow registers=0.
- **States**: IDLE (busy=0) and RUN (busy=1). Down-counter width is ⌈log2(max latency+1)⌉.
- **Accept condition**: an edge with start=1, busy=0, flush=0.
  - Ops 1–4, 7–10: latch the op, compute the result into shadow {SH, SL}, load counter = latency−1, go to RUN. If latency=1, commit at the next edge.
  - Op 5 (mthi): HI←D1 at this edge, stays IDLE, no done.
  - Op 6 (mtlo): LO←D1 at this edge, stays IDLE, no done.
  - Ops 0, 11–15: no effect.
- **Ignored starts**: start while busy=1 is ignored with no state change; the pipeline guarantees this does not occur.
- **RUN**:
  - On each edge, counter decrements.
  - On the edge where counter=0: HI←SH, LO←SL, busy←0, done←1 for one cycle, go to IDLE.
- **Flush** (flush=1 at an edge):
  - RUN → IDLE; HI/LO keep their pre-op values; no done.
  - Also suppresses a same-edge accept, including mthi/mtlo.
  - Flush in IDLE with no start has no effect.
- **Arithmetic** (P = 2·WIDTH-bit product, wraps modulo 2^(2·WIDTH)):
  - mult/multu: {SH,SL} = signed/unsigned D1×D2.
  - madd(u): {SH,SL} = {HI,LO} + P, where HI/LO are the values at acceptance.
  - msub(u): {SH,SL} = {HI,LO} − P, where HI/LO are the values at acceptance.
  - div: SL = quotient truncated toward zero, SH = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (both div and divu): SH = D1, SL = all ones.
  - div with most-negative / −1: SL = most-negative, SH = 0.
- **Operand sampling**: operands are used only at the accept edge, so D1/D2 may change during RUN.

## Timing
- Accept at edge k:
  - busy=1 after edge k through edge k+L, where L is the op latency.
  - HI/LO update at edge k+L; busy falls at edge k+L.
  - done=1 between edges k+L and k+L+1.
- Back-to-back: a new start may be accepted at the same edge where busy falls only if the stall logic presents it. The unit samples busy before the edge, so that start is ignored; the earliest accept is edge k+L+1.
- mthi/mtlo: visible on HI/LO in the cycle after the accept edge.
- Flush at edge k+j (1≤j≤L): busy=0 after that edge; done stays 0.
- Reset asserted mid-RUN: outputs clear immediately without waiting for clk. Deassertion is synchronised externally.

## Test plan
Settings: WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
- **mult**: mult D1=0xFFFFFFFD, D2=7 → busy high exactly 5 cycles; at edge k+5, HI=0xFFFFFFFF and LO=0xFFFFFFEB; done pulses once.
- **div/divu**:
  - divu 0xFFFFFFFF / 0x10 → after 10 cycles, LO=0x0FFFFFFF, HI=0xF.
  - div 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Corner divides**:
  - div 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Accumulate**:
  - mthi 1, then mtlo 0xFFFFFFFF → each visible next cycle, with busy staying 0.
  - maddu 1×1 → HI=2, LO=0.
  - msub 1×1 → HI=1, LO=0xFFFFFFFF.
- **Flush and ignored start**:
  - Prior state HI=LO=0x55; div accepted, with start + mthi asserted during RUN (ignored).
  - flush at edge k+3 → busy low after k+3, HI=LO=0x55 unchanged, done never pulses.
- **Reset mid-operation**: reset low mid-mult, between clock edges → HI=LO=0 and busy=0 immediately. After release, a mult 2×3 gives LO=6, HI=0.

Source files
------------

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair.
// Results are computed at accept into shadow registers and committed after the op latency.
module mdu_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       mlu_op,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic             flush,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done
);

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   sh_q, sh_d, sl_q, sl_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               accept;
   logic               mul_signed;
   logic [2*WIDTH-1:0] prod, acc, quot_rem;

   function automatic logic [2*WIDTH-1:0] mul_prod(input logic             is_signed,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] sa, sb;
      if (is_signed) begin
         sa = {{WIDTH{a[WIDTH-1]}}, a};
         sb = {{WIDTH{b[WIDTH-1]}}, b};
      end else begin
         sa = {{WIDTH{1'b0}}, a};
         sb = {{WIDTH{1'b0}}, b};
      end
      return sa * sb;
   endfunction

   // Returns {remainder, quotient}; divide by zero yields {dividend, all ones}.
   function automatic logic [2*WIDTH-1:0] div_res(input logic             is_signed,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] ua, ub, q, r;
      logic             neg_q, neg_r;
      neg_q = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r = is_signed & a[WIDTH-1];
      ua    = (is_signed && a[WIDTH-1]) ? -a : a;
      ub    = (is_signed && b[WIDTH-1]) ? -b : b;
      if (b == '0) begin
         return {a, {WIDTH{1'b1}}};
      end
      q = ua / ub;
      r = ua % ub;
      if (neg_q) q = -q;
      if (neg_r) r = -r;
      return {r, q};
   endfunction

   assign busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;
   assign done = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      sl_d       = sl_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      accept     = start && (state_q == IDLE) && !flush;
      mul_signed = (mlu_op == OP_MULT) || (mlu_op == OP_MADD) || (mlu_op == OP_MSUB);
      prod       = mul_prod(mul_signed, D1, D2);
      acc        = {hi_q, lo_q};
      quot_rem   = div_res(mlu_op == OP_DIV, D1, D2);
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (mlu_op)
                  OP_MULT, OP_MULTU: begin
                     {sh_d, sl_d} = prod;
                     cnt_d        = MUL_LOAD;
                     state_d      = RUN;
                  end
                  OP_MADD, OP_MADDU: begin
                     {sh_d, sl_d} = acc + prod;
                     cnt_d        = MUL_LOAD;
                     state_d      = RUN;
                  end
                  OP_MSUB, OP_MSUBU: begin
                     {sh_d, sl_d} = acc - prod;
                     cnt_d        = MUL_LOAD;
                     state_d      = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     {sh_d, sl_d} = quot_rem;
                     cnt_d        = DIV_LOAD;
                     state_d      = RUN;
                  end
                  OP_MTHI: hi_d = D1;
                  OP_MTLO: lo_d = D1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Flush wins over a same-edge commit so HI/LO keep their pre-op values.
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               hi_d    = sh_q;
               lo_d    = sl_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         sl_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         sl_q    <= sl_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk = 1'b0;
   logic         reset, start, flush;
   logic [3:0]   mlu_op;
   logic [W-1:0] D1, D2, HI, LO;
   logic         busy, done;

   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] m_hi, m_lo;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mlu_op(mlu_op),
      .D1(D1), .D2(D2), .flush(flush),
      .HI(HI), .LO(LO), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {HI,LO} after an op, from 64-bit integer arithmetic.
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] sp, up, acc;
      sa  = $signed(a);
      sb  = $signed(b);
      sp  = 64'(sa * sb);
      up  = {32'b0, a} * {32'b0, b};
      acc = {hi, lo};
      case (op)
         4'd1:  return sp;
         4'd2:  return up;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         4'd5:  return {a, lo};
         4'd6:  return {hi, a};
         4'd7:  return acc + sp;
         4'd8:  return acc + up;
         4'd9:  return acc - sp;
         4'd10: return acc - up;
         default: return acc;
      endcase
   endfunction

   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          lat, n;
      logic [63:0] exp;
      lat    = (op == 4'd3 || op == 4'd4) ? DC : MC;
      exp    = ref_model(op, a, b, m_hi, m_lo);
      start  = 1'b1;
      mlu_op = op;
      D1     = a;
      D2     = b;
      @(posedge clk); #1;
      start  = 1'b0;
      mlu_op = 4'($urandom_range(1, 10));
      D1     = $urandom;
      D2     = $urandom;
      if (op == 4'd5 || op == 4'd6) begin
         check("mtx_busy", {63'b0, busy}, 64'd0);
         check("mtx_done", {63'b0, done}, 64'd0);
         check("mtx_hilo", {HI, LO}, exp);
      end else begin
         check("busy_after_accept", {63'b0, busy}, 64'd1);
         n = 0;
         while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check("latency", 64'(n), 64'(lat));
         check("done_pulse", {63'b0, done}, 64'd1);
         check("result", {HI, LO}, exp);
         @(posedge clk); #1;
         check("done_clear", {63'b0, done}, 64'd0);
      end
      {m_hi, m_lo} = exp;
   endtask

   initial begin
      logic        seen;
      int          sel;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b0; start = 1'b0; flush = 1'b0; mlu_op = 4'd0; D1 = '0; D2 = '0;
      m_hi = '0; m_lo = '0;
      #12;
      check("reset_hilo", {HI, LO}, 64'd0);
      check("reset_ctl", {62'b0, busy, done}, 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      do_op(4'd1, 32'hFFFFFFFD, 32'd7);
      check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
      do_op(4'd4, 32'hFFFFFFFF, 32'h10);
      check("divu_const", {HI, LO}, 64'h0000000F_0FFFFFFF);
      do_op(4'd3, 32'hFFFFFFF9, 32'd2);
      check("div_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      do_op(4'd3, 32'h1234, 32'd0);
      check("div_zero_const", {HI, LO}, 64'h00001234_FFFFFFFF);
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
      do_op(4'd4, 32'h55, 32'd0);
      check("divu_zero_const", {HI, LO}, 64'h00000055_FFFFFFFF);
      do_op(4'd5, 32'd1, 32'd0);
      do_op(4'd6, 32'hFFFFFFFF, 32'd0);
      check("mthi_mtlo_const", {HI, LO}, 64'h00000001_FFFFFFFF);
      do_op(4'd8, 32'd1, 32'd1);
      check("maddu_const", {HI, LO}, 64'h00000002_00000000);
      do_op(4'd9, 32'd1, 32'd1);
      check("msub_const", {HI, LO}, 64'h00000001_FFFFFFFF);

      // Flush mid-divide with an ignored mthi while running.
      do_op(4'd5, 32'h55, 32'd0);
      do_op(4'd6, 32'h55, 32'd0);
      start = 1'b1; mlu_op = 4'd3; D1 = 32'd100; D2 = 32'd7;
      @(posedge clk); #1;
      mlu_op = 4'd5; D1 = 32'hDEAD;
      check("flush_busy_run", {63'b0, busy}, 64'd1);
      @(posedge clk); #1;
      check("ignored_mthi", {HI, LO}, 64'h00000055_00000055);
      start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_low", {63'b0, busy}, 64'd0);
      check("flush_hilo", {HI, LO}, 64'h00000055_00000055);
      seen = done;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("flush_no_done", {63'b0, seen}, 64'd0);
      check("flush_hilo_late", {HI, LO}, 64'h00000055_00000055);

      start = 1'b1; flush = 1'b1; mlu_op = 4'd5; D1 = 32'h77;
      @(posedge clk); #1;
      check("flush_blocks_mthi", {HI, LO}, 64'h00000055_00000055);
      mlu_op = 4'd1; D1 = 32'd3; D2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_blocks_mult", {63'b0, busy}, 64'd0);

      // Asynchronous reset in the middle of a multiply.
      start = 1'b1; mlu_op = 4'd1; D1 = 32'd3; D2 = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("async_reset_hilo", {HI, LO}, 64'd0);
      check("async_reset_ctl", {62'b0, busy, done}, 64'd0);
      @(negedge clk); reset = 1'b1;
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      do_op(4'd1, 32'd2, 32'd3);
      check("mult_after_reset", {HI, LO}, 64'd6);

      repeat (40) begin
         rop = 4'($urandom_range(1, 10));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (rop == 4'd3 || rop == 4'd4) begin
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFFFFFF;
            else if (sel == 2) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
         end
         do_op(rop, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
